mc_incn_pipe: RTL and testbench



---
 rtl/mc_incn_pipe_pkg.sv | 24 ++
 rtl/mc_incn_seg.sv | 82 ++++++++
 rtl/mc_incn_pipe.sv | 95 +++++++++
 tb/tb_mc_incn_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_incn_pipe_pkg.sv
// Shared definitions for the pipelined address incrementer: mode encodings,
// default geometry and the segment-width helper used by the top level.
package mc_incn_pipe_pkg;

    // Mode encodings carried with every token (in_sat)
    localparam logic MC_INCN_WRAP = 1'b0;
    localparam logic MC_INCN_SAT  = 1'b1;

    // Default geometry: 32-bit addresses, two carry segments, 8-bit step
    localparam int MC_INCN_DEF_WIDTH  = 32;
    localparam int MC_INCN_DEF_STAGES = 2;
    localparam int MC_INCN_DEF_STEP_W = 8;

    // Width of every segment except possibly the last: ceil(width / stages).
    // A non-positive stage count returns the full width so that the caller's
    // own range check can report the problem instead of a divide by zero.
    function automatic int mc_incn_seg_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/mc_incn_seg.sv
// One carry segment of the incrementer pipeline. It adds its slice of the
// operand and step plus the carry from the previous stage, and registers the
// whole token (partially assembled result, remaining step, mode, carry, valid)
// for the next stage.
module mc_incn_seg
    import mc_incn_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SEG_LO = 0,
    parameter int SEG_N  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             sat_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] step_o,
    output logic             sat_o,
    output logic             carry_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;
    logic [WIDTH-1:0] step_d,  step_q;
    logic             sat_d,   sat_q;
    logic             carry_d, carry_q;
    logic [SEG_N:0]   seg_sum;

    // Segment adder and next-token selection; payload only loads for real tokens
    always_comb begin
        seg_sum = {1'b0, data_i[SEG_LO +: SEG_N]}
                + {1'b0, step_i[SEG_LO +: SEG_N]}
                + (SEG_N + 1)'(carry_i);

        valid_d = valid_q;
        data_d  = data_q;
        step_d  = step_q;
        sat_d   = sat_q;
        carry_d = carry_q;

        if (adv) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d                    = data_i;
                data_d[SEG_LO +: SEG_N]   = seg_sum[SEG_N-1:0];
                step_d                    = step_i;
                step_d[SEG_LO +: SEG_N]   = '0;
                sat_d                     = sat_i;
                carry_d                   = seg_sum[SEG_N];
            end
        end
    end

    // Stage registers, cleared asynchronously so in-flight tokens are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            step_q  <= '0;
            sat_q   <= MC_INCN_WRAP;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            step_q  <= step_d;
            sat_q   <= sat_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign step_o  = step_q;
    assign sat_o   = sat_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/mc_incn_pipe.sv
// Pipelined, carry-segmented address incrementer for the memory controller.
// STAGES segment stages are chained by a generate loop; one global advance
// signal moves or freezes the whole pipe, and the final saturation mux sits
// after the last stage register.
module mc_incn_pipe
    import mc_incn_pipe_pkg::*;
#(
    parameter int WIDTH  = MC_INCN_DEF_WIDTH,
    parameter int STAGES = MC_INCN_DEF_STAGES,
    parameter int STEP_W = MC_INCN_DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STEP_W-1:0] in_step,
    input  logic              in_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry
);

    localparam int SEG_W  = mc_incn_seg_width(WIDTH, STAGES);
    localparam int LAST_W = WIDTH - (STAGES - 1) * SEG_W;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH ||
        STEP_W < 1 || STEP_W > WIDTH || LAST_W <= 0) begin : g_bad_params
        $error("mc_incn_pipe: illegal WIDTH/STAGES/STEP_W combination");
    end

    // Token chain: index k feeds stage k, index k+1 is stage k's register
    logic             st_valid [0:STAGES];
    logic [WIDTH-1:0] st_data  [0:STAGES];
    logic [WIDTH-1:0] st_step  [0:STAGES-1];
    logic             st_sat   [0:STAGES];
    logic             st_carry [0:STAGES];
    logic [WIDTH-1:0] last_step_unused;
    logic             adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign st_valid[0] = in_valid;
    assign st_data[0]  = in_data;
    assign st_step[0]  = WIDTH'(in_step);
    assign st_sat[0]   = in_sat;
    assign st_carry[0] = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int SEG_LO = k * SEG_W;
        localparam int SEG_N  = (k == STAGES - 1) ? LAST_W : SEG_W;

        logic [WIDTH-1:0] step_nxt;

        mc_incn_seg #(
            .WIDTH  (WIDTH),
            .SEG_LO (SEG_LO),
            .SEG_N  (SEG_N)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .valid_i (st_valid[k]),
            .data_i  (st_data[k]),
            .step_i  (st_step[k]),
            .sat_i   (st_sat[k]),
            .carry_i (st_carry[k]),
            .valid_o (st_valid[k+1]),
            .data_o  (st_data[k+1]),
            .step_o  (step_nxt),
            .sat_o   (st_sat[k+1]),
            .carry_o (st_carry[k+1])
        );

        if (k < STAGES - 1) begin : g_step_fwd
            assign st_step[k+1] = step_nxt;
        end else begin : g_step_end
            assign last_step_unused = step_nxt;
        end
    end

    assign out_valid = st_valid[STAGES];
    assign out_carry = st_carry[STAGES];

    // Saturate to all-ones when the token asked for it and the sum overflowed
    always_comb begin
        out_data = st_data[STAGES];
        if (st_sat[STAGES] == MC_INCN_SAT && st_carry[STAGES]) begin
            out_data = '1;
        end
    end

endmodule

// File: tb/tb_mc_incn_pipe.sv
// Directed self-checking bench for mc_incn_pipe: a 32-bit/2-stage instance
// (A) and a 13-bit/3-stage instance (B) with hand-computed results.
module tb_mc_incn_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        a_in_valid, a_in_ready, a_in_sat;
    logic [31:0] a_in_data;
    logic [7:0]  a_in_step;
    logic        a_out_valid, a_out_ready, a_out_carry;
    logic [31:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_in_sat;
    logic [12:0] b_in_data;
    logic [7:0]  b_in_step;
    logic        b_out_valid, b_out_ready, b_out_carry;
    logic [12:0] b_out_data;

    int compared   = 0;
    int mismatched = 0;

    mc_incn_pipe #(.WIDTH(32), .STAGES(2), .STEP_W(8)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_step   (a_in_step),
        .in_sat    (a_in_sat),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_carry (a_out_carry)
    );

    mc_incn_pipe #(.WIDTH(13), .STAGES(3), .STEP_W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_step   (b_in_step),
        .in_sat    (b_in_sat),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_carry (b_out_carry)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [7:0] s, input logic sat);
        a_in_valid = v;
        a_in_data  = d;
        a_in_step  = s;
        a_in_sat   = sat;
    endtask

    task automatic applyStimulusB(input logic v, input logic [12:0] d, input logic [7:0] s, input logic sat);
        b_in_valid = v;
        b_in_data  = d;
        b_in_step  = s;
        b_in_sat   = sat;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] ed, input logic ec);
        checkValue({tag, ".valid"}, 32'(a_out_valid), 32'd1);
        checkValue({tag, ".data"},  a_out_data, ed);
        checkValue({tag, ".carry"}, 32'(a_out_carry), 32'(ec));
    endtask

    task automatic checkOutputB(input string tag, input logic [12:0] ed, input logic ec);
        checkValue({tag, ".valid"}, 32'(b_out_valid), 32'd1);
        checkValue({tag, ".data"},  32'(b_out_data), 32'(ed));
        checkValue({tag, ".carry"}, 32'(b_out_carry), 32'(ec));
    endtask

    // One isolated operand through A: two edges of latency
    task automatic sendOne(input string tag, input logic [31:0] d, input logic [7:0] s,
                           input logic sat, input logic [31:0] ed, input logic ec);
        applyStimulus(1'b1, d, s, sat);
        tick();
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0);
        checkValue({tag, ".early"}, 32'(a_out_valid), 32'd0);
        tick();
        checkOutput(tag, ed, ec);
    endtask

    // One isolated operand through B: three edges of latency
    task automatic sendOneB(input string tag, input logic [12:0] d, input logic [7:0] s,
                            input logic sat, input logic [12:0] ed, input logic ec);
        applyStimulusB(1'b1, d, s, sat);
        tick();
        applyStimulusB(1'b0, 13'h0, 8'h0, 1'b0);
        checkValue({tag, ".early1"}, 32'(b_out_valid), 32'd0);
        tick();
        checkValue({tag, ".early2"}, 32'(b_out_valid), 32'd0);
        tick();
        checkOutputB(tag, ed, ec);
    endtask

    // Directed sequence
    initial begin
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0);
        applyStimulusB(1'b0, 13'h0, 8'h0, 1'b0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        checkValue("rst.a_valid", 32'(a_out_valid), 32'd0);
        checkValue("rst.a_data",  a_out_data, 32'h0);
        checkValue("rst.a_carry", 32'(a_out_carry), 32'd0);
        checkValue("rst.a_ready", 32'(a_in_ready), 32'd1);
        checkValue("rst.b_valid", 32'(b_out_valid), 32'd0);
        checkValue("rst.b_data",  32'(b_out_data), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkValue("rel.a_valid", 32'(a_out_valid), 32'd0);

        // Single operands through A
        sendOne("a_xseg",     32'h0000FFFF, 8'h01, 1'b0, 32'h00010000, 1'b0);
        sendOne("a_wrap",     32'hFFFFFFFF, 8'h01, 1'b0, 32'h00000000, 1'b1);
        sendOne("a_sat",      32'hFFFFFFFF, 8'h01, 1'b1, 32'hFFFFFFFF, 1'b1);
        sendOne("a_step_ff",  32'h12345678, 8'hFF, 1'b0, 32'h12345777, 1'b0);
        sendOne("a_step0",    32'h12345678, 8'h00, 1'b0, 32'h12345678, 1'b0);
        sendOne("a_sat_nc",   32'hFFFFFF00, 8'hFF, 1'b1, 32'hFFFFFFFF, 1'b0);
        sendOne("a_sat_lo",   32'h00000010, 8'h20, 1'b1, 32'h00000030, 1'b0);

        // Four back-to-back operands with a three-cycle output stall
        tick();
        checkValue("bb.idle", 32'(a_out_valid), 32'd0);
        applyStimulus(1'b1, 32'h00000100, 8'h01, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00000200, 8'h01, 1'b0);
        tick();
        checkOutput("bb.r1", 32'h00000101, 1'b0);
        a_out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00000300, 8'h01, 1'b0);
        #1;
        checkValue("bb.stall0.ready", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkValue("bb.stall.ready", 32'(a_in_ready), 32'd0);
            checkOutput("bb.stall.hold", 32'h00000101, 1'b0);
        end
        a_out_ready = 1'b1;
        #1;
        checkValue("bb.unstall.ready", 32'(a_in_ready), 32'd1);
        tick();
        checkOutput("bb.r2", 32'h00000201, 1'b0);
        applyStimulus(1'b1, 32'h00000400, 8'h01, 1'b0);
        tick();
        checkOutput("bb.r3", 32'h00000301, 1'b0);
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0);
        tick();
        checkOutput("bb.r4", 32'h00000401, 1'b0);
        tick();
        checkValue("bb.drain", 32'(a_out_valid), 32'd0);

        // Mid-flight reset with two tokens in the pipe
        applyStimulus(1'b1, 32'h0000AAAA, 8'h05, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0000BBBB, 8'h05, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("mr.pre", 32'h0000AAAF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkValue("mr.valid", 32'(a_out_valid), 32'd0);
        checkValue("mr.data",  a_out_data, 32'h0);
        checkValue("mr.carry", 32'(a_out_carry), 32'd0);
        checkValue("mr.ready", 32'(a_in_ready), 32'd1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkValue("mr.quiet", 32'(a_out_valid), 32'd0);
        end
        sendOne("mr.after", 32'h00000001, 8'h02, 1'b0, 32'h00000003, 1'b0);

        // Three-stage instance, segments 5/5/3
        sendOneB("b_seg12",  13'h0FFF, 8'h01, 1'b0, 13'h1000, 1'b0);
        sendOneB("b_wrap",   13'h1FFF, 8'h01, 1'b0, 13'h0000, 1'b1);
        sendOneB("b_sat",    13'h1FFF, 8'h01, 1'b1, 13'h1FFF, 1'b1);
        sendOneB("b_seg01",  13'h03FF, 8'h01, 1'b0, 13'h0400, 1'b0);
        sendOneB("b_step",   13'h0123, 8'hF0, 1'b0, 13'h0213, 1'b0);
        tick();
        checkValue("b.drain", 32'(b_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
